// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller with an IF/ID pipeline register.
// Sequencing is IDLE -> RUN -> DRAIN -> HALT. A taken branch (branch & zero)
// arriving in RUN or DRAIN redirects the PC and squashes IF/ID. Fetching an
// ECALL (32'h0000_0073) holds the PC and drains the pipe for DRAIN_CYC cycles,
// then halts until the next reset.
// Optional feature: define FETCH_CTRL_PERF_EN to add the fetch_cnt and
// redirect_cnt performance counter outputs.
module fetch_ctrl #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = '0,
  parameter int                 DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [31:0]      ifid_inst,
  output logic [WIDTH-1:0] ifid_pc,
  output logic [WIDTH-1:0] ifid_pc4,
  output logic             flush,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      redirect_cnt,
`endif
  output logic [1:0]       state,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [31:0]      ECALL_INST = 32'h0000_0073;
  localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYC);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;
  logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [2:0]       drain_q, drain_d;

  logic             redirect;
  logic             fetch_load;
  logic [WIDTH-1:0] pc_plus4;

  // A taken branch only acts while the pipe is live (RUN or DRAIN).
  assign redirect = branch & zero & ((state_q == S_RUN) | (state_q == S_DRAIN));
  // Adder wraps modulo 2^WIDTH by construction.
  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state logic: redirect beats stall, stall beats ECALL detection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    drain_d      = drain_q;
    fetch_load   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pc_d         = RESET_PC;
        ifid_valid_d = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          pc_d         = {br_target[WIDTH-1:2], 2'b00};
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          fetch_load   = 1'b1;
          ifid_inst_d  = imem_rdata;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          if (imem_rdata == ECALL_INST) begin
            // PC parks on the ECALL so the halted core points at it.
            drain_d = DRAIN_INIT;
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d         = {br_target[WIDTH-1:2], 2'b00};
          ifid_valid_d = 1'b0;
          drain_d      = 3'd0;
          state_d      = S_RUN;
        end else begin
          // Countdown ignores stall: the drain is a fixed-length window.
          ifid_valid_d = 1'b0;
          drain_d      = drain_q - 3'd1;
          if (drain_d == 3'd0) state_d = S_HALT;
        end
      end
      default: begin
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  // Control and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      drain_q      <= drain_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;

  // Performance counters: IF/ID loads and flush cycles, both free-running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (fetch_load) fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (redirect)   redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign flush      = redirect;
  assign state      = state_q;
  assign done       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Instruction memory returns
// NOP (0x13) everywhere except an optional ECALL at a chosen address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, branch, zero;
  logic [31:0] br_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
  logic        flush;
  logic [1:0]  state;
  logic        done;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt;
`endif

  logic        ecall_en;
  logic [31:0] ecall_addr;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branch(branch), .zero(zero), .br_target(br_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .flush(flush),
`ifdef FETCH_CTRL_PERF_EN
    .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt),
`endif
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = 32'h0000_0013;
    if (ecall_en && imem_addr == ecall_addr) imem_rdata = 32'h0000_0073;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b1; zero = 1'b1;
    br_target = 32'h0; ecall_en = 1'b0; ecall_addr = 32'h8;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_inst", ifid_inst, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("idle_flush", 32'(flush), 32'd0);
    tick();
    rst = 1'b1; branch = 1'b0; zero = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    // Start held high: one transition, later start ignored
    start = 1'b1;
    tick();
    chk("run_state", 32'(state), 32'd1);
    chk("run_valid0", 32'(ifid_valid), 32'd0);
    tick();
    chk("f0_pc", ifid_pc, 32'h0);
    chk("f0_valid", 32'(ifid_valid), 32'd1);
    chk("f0_inst", ifid_inst, 32'h13);
    chk("f0_pc4", ifid_pc4, 32'h4);
    chk("f0_addr", imem_addr, 32'h4);
    tick();
    chk("f1_pc", ifid_pc, 32'h4);
    tick();
    chk("f2_pc", ifid_pc, 32'h8);
    tick();
    chk("f3_pc", ifid_pc, 32'hc);
    chk("f3_addr", imem_addr, 32'h10);
    chk("start_ign", 32'(state), 32'd1);
    start = 1'b0;

    // Stall three cycles at 0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_pc", ifid_pc, 32'hc);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", ifid_pc, 32'h10);
    chk("unstall_addr", imem_addr, 32'h14);

    // Redirect beats stall; target is word-aligned
    branch = 1'b1; zero = 1'b1; stall = 1'b1; br_target = 32'h43;
    #1;
    chk("br_flush", 32'(flush), 32'd1);
    tick();
    chk("br_addr", imem_addr, 32'h40);
    chk("br_valid", 32'(ifid_valid), 32'd0);
    branch = 1'b0; zero = 1'b0; stall = 1'b0;
    #1;
    chk("br_noflush", 32'(flush), 32'd0);
    tick();
    chk("br_pc", ifid_pc, 32'h40);
    chk("br_valid1", 32'(ifid_valid), 32'd1);

    // Back to 0 and hit ECALL at 0x08
    branch = 1'b1; zero = 1'b1; br_target = 32'h0;
    tick();
    branch = 1'b0; zero = 1'b0; ecall_en = 1'b1;
    tick();
    tick();
    chk("ec_pre_addr", imem_addr, 32'h8);
    tick();
    chk("ec_state", 32'(state), 32'd2);
    chk("ec_inst", ifid_inst, 32'h73);
    chk("ec_pc", ifid_pc, 32'h8);
    chk("ec_valid", 32'(ifid_valid), 32'd1);
    chk("ec_addr", imem_addr, 32'h8);
    stall = 1'b1;
    tick();
    chk("dr1_state", 32'(state), 32'd2);
    chk("dr1_valid", 32'(ifid_valid), 32'd0);
    tick();
    chk("dr2_state", 32'(state), 32'd2);
    tick();
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_addr", imem_addr, 32'h8);
    stall = 1'b0;
    branch = 1'b1; zero = 1'b1; br_target = 32'h20;
    #1;
    chk("halt_noflush", 32'(flush), 32'd0);
    tick();
    chk("halt_stay", 32'(state), 32'd3);
    chk("halt_addr2", imem_addr, 32'h8);
    branch = 1'b0; zero = 1'b0;

    // Reset out of HALT, rerun to ECALL, redirect during DRAIN
    #2 rst = 1'b0;
    #1;
    chk("hrst_state", 32'(state), 32'd0);
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_state", 32'(state), 32'd1);
    tick();
    tick();
    tick();
    chk("r2_drain", 32'(state), 32'd2);
    branch = 1'b1; zero = 1'b1; br_target = 32'h20;
    #1;
    chk("dr_flush", 32'(flush), 32'd1);
    tick();
    chk("dr_state", 32'(state), 32'd1);
    chk("dr_addr", imem_addr, 32'h20);
    chk("dr_valid", 32'(ifid_valid), 32'd0);
    branch = 1'b0; zero = 1'b0; ecall_en = 1'b0;
    tick();
    chk("dr_pc", ifid_pc, 32'h20);
    chk("dr_valid1", 32'(ifid_valid), 32'd1);

    // Reset mid-RUN at 0x18
    branch = 1'b1; zero = 1'b1; br_target = 32'h18;
    tick();
    branch = 1'b0; zero = 1'b0;
    chk("m_addr", imem_addr, 32'h18);
    #2 rst = 1'b0;
    #1;
    chk("m_state", 32'(state), 32'd0);
    chk("m_addr0", imem_addr, 32'h0);
    chk("m_valid", 32'(ifid_valid), 32'd0);
    chk("m_inst", ifid_inst, 32'h0);
    chk("m_pc", ifid_pc, 32'h0);
    chk("m_pc4", ifid_pc4, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("m_fcnt", fetch_cnt, 32'h0);
    chk("m_rcnt", redirect_cnt, 32'h0);
`endif
    tick();
    rst = 1'b1;
    tick();
    chk("m_needstart", 32'(state), 32'd0);

    // PC+4 wraps at the top of the address space
    start = 1'b1;
    tick();
    start = 1'b0;
    branch = 1'b1; zero = 1'b1; br_target = 32'hFFFF_FFFF;
    #1;
    chk("w_flush", 32'(flush), 32'd1);
    tick();
    branch = 1'b0; zero = 1'b0;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_CTRL_PERF_EN
    chk("w_rcnt", redirect_cnt, 32'd1);
    chk("w_fcnt0", fetch_cnt, 32'd0);
`endif
    tick();
    chk("w_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("w_pc4", ifid_pc4, 32'h0);
    chk("w_addr0", imem_addr, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("w_fcnt1", fetch_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
